// File: rtl/aurora_cmd_wbexec.sv
// Executes split Aurora address/data command streams as Wishbone classic single cycles
// and returns read data as a single-beat AXI4-Stream response. Optional macro: AURORA_CMD_WBEXEC_TIMEOUT_EN.
module aurora_cmd_wbexec #(
    parameter int          ADDR_BITS      = 22,
    parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [31:0]          s_cmd_addr_tdata,
    input  logic                 s_cmd_addr_tvalid,
    output logic                 s_cmd_addr_tready,
    input  logic [31:0]          s_cmd_data_tdata,
    input  logic                 s_cmd_data_tvalid,
    output logic                 s_cmd_data_tready,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADDR_BITS-1:0] wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic [31:0]          m_resp_tdata,
    output logic                 m_resp_tvalid,
    input  logic                 m_resp_tready,
    output logic                 m_resp_tlast,
    output logic                 bus_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_BITS-1:0]  adr_q, adr_d;
    logic [31:0]           dat_q, dat_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  bus_err_q, bus_err_d;

    logic                  rd_go_s;
    logic                  wr_go_s;
    logic                  timeout_s;
    logic                  bus_done_s;
    logic                  unused_s;

    // A read is only accepted when the response register is already empty.
    assign rd_go_s = (state_q == ST_IDLE) && s_cmd_addr_tvalid && s_cmd_addr_tdata[31] && !resp_valid_q;
    assign wr_go_s = (state_q == ST_IDLE) && s_cmd_addr_tvalid && !s_cmd_addr_tdata[31] && s_cmd_data_tvalid;

    assign s_cmd_addr_tready = aresetn & (rd_go_s | wr_go_s);
    assign s_cmd_data_tready = aresetn & wr_go_s;

`ifdef AURORA_CMD_WBEXEC_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Ack-wait counter: zero while idle, counts every bus cycle without ack/err.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (!wb_ack_i && !wb_err_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_s = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign unused_s  = ^s_cmd_addr_tdata;
`else
    assign timeout_s = 1'b0;
    assign unused_s  = ^{s_cmd_addr_tdata, 32'(TIMEOUT_CYCLES)};
`endif

    assign bus_done_s = wb_ack_i | wb_err_i | timeout_s;

    // Next-state and next-output computation for the command executor.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        bus_err_d    = 1'b0;

        if (resp_valid_q && m_resp_tready) begin
            resp_valid_d = 1'b0;
            resp_data_d  = 32'h0000_0000;
        end else begin
            resp_valid_d = resp_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_go_s) begin
                    state_d = ST_READ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = s_cmd_addr_tdata[ADDR_BITS-1:0];
                end else if (wr_go_s) begin
                    state_d = ST_WRITE;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = s_cmd_addr_tdata[ADDR_BITS-1:0];
                    dat_d   = s_cmd_data_tdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE, ST_READ: begin
                if (bus_done_s) begin
                    state_d   = ST_IDLE;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    bus_err_d = !wb_ack_i;
                    if (state_q == ST_READ) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = wb_ack_i ? wb_dat_i : ERR_DATA;
                    end else begin
                        resp_valid_d = resp_valid_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any cycle and drops a pending response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= {ADDR_BITS{1'b0}};
            dat_q        <= 32'h0000_0000;
            resp_data_q  <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = stb_q;
    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = 4'hF;
    assign m_resp_tdata  = resp_data_q;
    assign m_resp_tvalid = resp_valid_q;
    assign m_resp_tlast  = 1'b1;
    assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_aurora_cmd_wbexec.sv
// Directed bench for aurora_cmd_wbexec: writes, reads, back-pressure, stalls, errors, reset.
module tb_aurora_cmd_wbexec;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_cmd_addr_tdata = 32'h0;
    logic        s_cmd_addr_tvalid = 1'b0;
    logic        s_cmd_addr_tready;
    logic [31:0] s_cmd_data_tdata = 32'h0;
    logic        s_cmd_data_tvalid = 1'b0;
    logic        s_cmd_data_tready;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [21:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [31:0] m_resp_tdata;
    logic        m_resp_tvalid;
    logic        m_resp_tready = 1'b0;
    logic        m_resp_tlast;
    logic        bus_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    aurora_cmd_wbexec #(
        .ADDR_BITS      (22),
        .ERR_DATA       (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_cmd_addr_tdata  (s_cmd_addr_tdata),
        .s_cmd_addr_tvalid (s_cmd_addr_tvalid),
        .s_cmd_addr_tready (s_cmd_addr_tready),
        .s_cmd_data_tdata  (s_cmd_data_tdata),
        .s_cmd_data_tvalid (s_cmd_data_tvalid),
        .s_cmd_data_tready (s_cmd_data_tready),
        .wb_cyc_o          (wb_cyc_o),
        .wb_stb_o          (wb_stb_o),
        .wb_we_o           (wb_we_o),
        .wb_adr_o          (wb_adr_o),
        .wb_dat_o          (wb_dat_o),
        .wb_sel_o          (wb_sel_o),
        .wb_dat_i          (wb_dat_i),
        .wb_ack_i          (wb_ack_i),
        .wb_err_i          (wb_err_i),
        .m_resp_tdata      (m_resp_tdata),
        .m_resp_tvalid     (m_resp_tvalid),
        .m_resp_tready     (m_resp_tready),
        .m_resp_tlast      (m_resp_tlast),
        .bus_err_o         (bus_err_o)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int cyc_cnt;

        // Reset state
        #12;
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_tvalid", {31'd0, m_resp_tvalid}, 32'd0);
        check("rst_adr", {10'd0, wb_adr_o}, 32'd0);
        check("rst_consts", {26'd0, wb_sel_o, m_resp_tlast, bus_err_o}, {26'd0, 4'hF, 1'b1, 1'b0});
        aresetn = 1'b1;
        tick();

        // Write 0x10 / 0xCAFEF00D, ack on the second bus cycle
        s_cmd_addr_tdata = 32'h0000_0010; s_cmd_addr_tvalid = 1'b1;
        s_cmd_data_tdata = 32'hCAFE_F00D; s_cmd_data_tvalid = 1'b1;
        #1;
        check("wr_readys", {30'd0, s_cmd_addr_tready, s_cmd_data_tready}, 32'd3);
        tick();
        s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
        check("wr_ctl1", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd7);
        check("wr_adr", {10'd0, wb_adr_o}, 32'h10);
        check("wr_dat", wb_dat_o, 32'hCAFE_F00D);
        tick();
        check("wr_ctl2", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd7);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("wr_end", {29'd0, wb_cyc_o, m_resp_tvalid, bus_err_o}, 32'd0);

        // Read 0x80000024 returning 0x12345678 with response ready
        m_resp_tready = 1'b1;
        s_cmd_addr_tdata = 32'h8000_0024; s_cmd_addr_tvalid = 1'b1;
        #1;
        check("rd_readys", {30'd0, s_cmd_addr_tready, s_cmd_data_tready}, 32'd2);
        tick();
        s_cmd_addr_tvalid = 1'b0;
        check("rd_ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd6);
        check("rd_adr", {10'd0, wb_adr_o}, 32'h24);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        tick();
        wb_ack_i = 1'b0;
        check("rd_resp", {29'd0, wb_cyc_o, m_resp_tvalid, m_resp_tlast}, 32'd3);
        check("rd_data", m_resp_tdata, 32'h1234_5678);
        tick();
        check("rd_taken", {31'd0, m_resp_tvalid}, 32'd0);

        // Two reads with the response held: second waits for the register to drain
        m_resp_tready = 1'b0;
        s_cmd_addr_tdata = 32'h8000_0004; s_cmd_addr_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_5A5A;
        tick();
        wb_ack_i = 1'b0;
        check("bp_resp1", m_resp_tdata, 32'hA5A5_5A5A);
        s_cmd_addr_tdata = 32'h8000_0008; s_cmd_addr_tvalid = 1'b1;
        #1;
        check("bp_nopop", {31'd0, s_cmd_addr_tready}, 32'd0);
        tick(); tick(); tick();
        check("bp_hold", {30'd0, wb_cyc_o, s_cmd_addr_tready}, 32'd0);
        check("bp_stable", {m_resp_tdata[31:1], m_resp_tvalid}, {31'h52D2_AD2D, 1'b1});
        m_resp_tready = 1'b1;
        #1;
        check("bp_bubble", {31'd0, s_cmd_addr_tready}, 32'd0);
        tick();
        check("bp_drained", {30'd0, m_resp_tvalid, s_cmd_addr_tready}, 32'd1);
        tick();
        s_cmd_addr_tvalid = 1'b0;
        check("bp_rd2", {10'd0, wb_cyc_o, wb_adr_o}, {10'd0, 1'b1, 22'h8});
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_BEEF;
        tick();
        wb_ack_i = 1'b0;
        check("bp_resp2", m_resp_tdata, 32'h0BAD_BEEF);
        tick();

        // Write address waits five cycles for its data; orphan data is never popped
        s_cmd_addr_tdata = 32'h0000_0030; s_cmd_addr_tvalid = 1'b1;
        s_cmd_data_tdata = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wd_wait", {29'd0, wb_cyc_o, s_cmd_addr_tready, s_cmd_data_tready}, 32'd0);
        end
        s_cmd_data_tvalid = 1'b1;
        #1;
        check("wd_pop", {30'd0, s_cmd_addr_tready, s_cmd_data_tready}, 32'd3);
        tick();
        s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
        check("wd_bus", {wb_dat_o[31:3], wb_cyc_o, wb_we_o, wb_adr_o[4]}, {29'h0AAA_B555, 3'b111});
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        s_cmd_data_tvalid = 1'b1;
        tick();
        check("orphan", {30'd0, s_cmd_data_tready, wb_cyc_o}, 32'd0);
        s_cmd_data_tvalid = 1'b0;

        // Read with bus error
        s_cmd_addr_tdata = 32'h8000_0040; s_cmd_addr_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
        wb_err_i = 1'b1;
        tick();
        wb_err_i = 1'b0;
        check("err_rd", {30'd0, m_resp_tvalid, bus_err_o}, 32'd3);
        check("err_data", m_resp_tdata, 32'hFFFF_FFFF);
        tick();
        check("err_pulse", {30'd0, bus_err_o, m_resp_tvalid}, 32'd0);

        // Write with bus error
        s_cmd_addr_tdata = 32'h0000_0044; s_cmd_addr_tvalid = 1'b1; s_cmd_data_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
        wb_err_i = 1'b1;
        tick();
        wb_err_i = 1'b0;
        check("err_wr", {29'd0, wb_cyc_o, m_resp_tvalid, bus_err_o}, 32'd1);
        tick();

        // Ack and err together: ack wins
        s_cmd_addr_tdata = 32'h8000_0048; s_cmd_addr_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h0000_7777;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check("ackerr", {m_resp_tdata[15:0], 14'd0, m_resp_tvalid, bus_err_o}, {16'h7777, 14'd0, 2'b10});
        tick();

`ifdef AURORA_CMD_WBEXEC_TIMEOUT_EN
        // Slave never answers: cycle ends after 16 bus cycles
        s_cmd_addr_tdata = 32'h8000_0050; s_cmd_addr_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
        cyc_cnt = 0;
        while (wb_cyc_o && cyc_cnt < 40) begin
            cyc_cnt++;
            tick();
        end
        check("to_len", cyc_cnt, 32'd16);
        check("to_resp", {30'd0, m_resp_tvalid, bus_err_o}, 32'd3);
        check("to_data", m_resp_tdata, 32'hFFFF_FFFF);
        tick();
`else
        cyc_cnt = 0;
`endif

        // Asynchronous reset in the middle of a read
        m_resp_tready = 1'b0;
        s_cmd_addr_tdata = 32'h8000_0060; s_cmd_addr_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
        check("ar_cyc", {31'd0, wb_cyc_o}, 32'd1);
        aresetn = 1'b0;
        #1;
        check("ar_drop", {29'd0, wb_cyc_o, wb_stb_o, m_resp_tvalid}, 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_0001;
        tick();
        wb_ack_i = 1'b0;
        aresetn = 1'b1;
        tick(); tick();
        check("ar_noresp", {30'd0, m_resp_tvalid, wb_cyc_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aurora_cmd_wbexec.md
Name: aurora_cmd_wbexec

Overview:
- Executes the split command streams from the Aurora command generator as Wishbone classic single cycles.
- Inputs: address stream (bit 31 set = read, clear = write) and data stream (write payload).
- Performs one bus cycle per command; returns read data as a single-beat AXI4-Stream response.
- Sits between the Aurora command path and the TURFIO register bus; its flow control guarantees a read never starts without somewhere to put its result.

Parameters:
- ADDR_BITS, 22, width of wb_adr_o; taken from s_cmd_addr_tdata[ADDR_BITS-1:0]; legal range 1..31.
- ERR_DATA, 32'hFFFFFFFF, read response data on a bus error (or timeout).
- TIMEOUT_CYCLES, 255, ack wait limit in cycles (used only with the optional feature).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_cmd_addr_tdata  in  32  command word: [31] read flag, [ADDR_BITS-1:0] address.
- s_cmd_addr_tvalid  in  1 / s_cmd_addr_tready  out  1  address stream handshake.
- s_cmd_data_tdata  in  32  write data.
- s_cmd_data_tvalid  in  1 / s_cmd_data_tready  out  1  data stream handshake.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls.
- wb_adr_o  out  ADDR_BITS / wb_dat_o  out  32 / wb_sel_o  out  4 (constant 4'hF).
- wb_dat_i  in  32 / wb_ack_i  in  1 / wb_err_i  in  1.
- m_resp_tdata  out  32 / m_resp_tvalid  out  1 / m_resp_tready  in  1 / m_resp_tlast  out  1 (constant 1).
- bus_err_o  out  1  one-cycle pulse per errored or timed-out cycle.

Behaviour:
- Reset (async, aresetn=0): state IDLE. cyc, stb, we, tready outputs, m_resp_tvalid and bus_err_o go to 0 immediately. adr, dat and m_resp_tdata go to 0. A bus cycle in flight is abandoned and a pending response is discarded.
- States: IDLE, WRITE, READ.
- IDLE → READ:
  - Condition: addr_tvalid && addr_tdata[31] && !m_resp_tvalid.
  - s_cmd_addr_tready=1 combinationally that cycle.
  - Register the address; assert cyc=stb=1, we=0 next cycle.
- IDLE → WRITE:
  - Condition: addr_tvalid && !addr_tdata[31] && data_tvalid.
  - Both treadys=1 that cycle; register address and data; assert cyc=stb=we=1 next cycle.
- IDLE hold cases:
  - Write address valid but data not yet valid: no pop, no bus cycle.
  - Read pending while response register still full: no pop, no bus cycle (deadlock avoidance).
  - s_cmd_data_tready is never asserted without a simultaneous write-address pop. Orphan data is never consumed.
- READ/WRITE exit on wb_ack_i or wb_err_i (ack takes priority if both are high):
  - cyc, stb and we drop the next cycle; return to IDLE.
  - READ with ack: m_resp_tdata←wb_dat_i, m_resp_tvalid←1.
  - READ with err: m_resp_tdata←ERR_DATA, m_resp_tvalid←1.
  - err (without ack): bus_err_o pulses for one cycle.
- Response register:
  - m_resp_tdata is held stable while tvalid && !tready.
  - Cleared on tvalid && tready.
  - A new read may be accepted in the same cycle the response is taken only if the register is clear at the start of that cycle. That is: no same-cycle fall-through; one bubble.
- Timing:
  - Minimum one IDLE cycle between transactions.
  - Accept at cycle N, cyc/stb at N+1, ack at N+k (k≥1), response tvalid at N+k+1.
  - Throughput bound for zero-wait-state slaves: one command per 3 cycles.
- wb_adr_o and wb_dat_o are stable for the entire cycle.

Optional Feature:
- Macro: AURORA_CMD_WBEXEC_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to READ/WRITE and increments each cycle without ack/err.
  - On reaching TIMEOUT_CYCLES, the cycle ends exactly as err does: cyc/stb drop next cycle, bus_err_o pulses, a read returns ERR_DATA.
  - An ack in the same cycle as the limit wins.
- Undefined: no counter; READ/WRITE wait indefinitely; TIMEOUT_CYCLES is ignored.

Test Plan:
- Write, addr 0x00000010 + data 0xCAFEF00D, ack on the 2nd bus cycle → both streams popped in one cycle; wb_adr=0x10, dat=0xCAFEF00D, we=1 for 2 cycles; no response beat.
- Read addr 0x80000024, slave returns 0x12345678, m_resp_tready=1 → wb_adr=0x24, we=0; m_resp_tdata=0x12345678, tlast=1 one cycle after ack.
- Two reads with m_resp_tready=0 → first completes; second address not popped (tready=0, cyc=0) until the response is consumed; then it proceeds.
- Write address valid, data valid 5 cycles later → no cyc and no pop until data valid; then the normal write.
- Read with wb_err_i=1 → response 0xFFFFFFFF, bus_err_o one pulse; a write with err gives the bus_err_o pulse only.
- With AURORA_CMD_WBEXEC_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks → cyc drops after 16 cycles; response ERR_DATA; bus_err_o pulses. Also assert aresetn mid-cycle → cyc=0 immediately, no response.
